imm_ext_ctrl: RTL and testbench
===============================

Name: imm_ext_ctrl

Overview:
- Registered immediate-extension stage between instruction decode and the ID/EX pipeline register.
- Decodes the 6-bit opcode to select zero-extend, sign-extend, LUI-shift or branch-offset mode, then produces the 32-bit operand.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes on both sides, so downstream stalls never drop an immediate.
- Supports pipeline flush and keeps a zero-extend usage counter for performance monitoring.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4.
- CNT_W, 16, width of the zero-extend usage counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  opcode/immediate pair presented.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  6  instruction opcode field.
- in_imm  input  16  raw immediate field.
- flush  input  1  discard all buffered entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_imm  output  32  extended immediate of head entry.
- out_mode  output  2  mode of head entry: 0 sign, 1 zero, 2 lui, 3 branch.
- zext_count  output  CNT_W  count of zero-mode entries delivered.

Behaviour:
- Reset: asserting reset asynchronously clears all state regardless of clk.
  - FIFO empty, pointers 0, out_valid=0, out_imm=0, out_mode=0, zext_count=0.
  - in_ready=1 from the first edge after reset deasserts.
- Mode decode (combinational on input, stored with the entry):
  - 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI) -> zero: {16'h0000, imm}.
  - 0x0F (LUI) -> lui: {imm, 16'h0000}.
  - 0x04, 0x05 (BEQ/BNE) -> branch: {{14{imm[15]}}, imm, 2'b00}.
  - All other opcodes -> sign: {{16{imm[15]}}, imm}.
- Handshakes:
  - Push occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - in_ready = (count < DEPTH); it depends only on registered state, not on out_ready.
  - out_valid = (count != 0); out_imm and out_mode are driven from the head entry (registered storage, no combinational path from in_* to out_*).
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. Minimum latency is 1 cycle.
- Throughput: 1 entry per cycle when out_ready is held high.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at any count below DEPTH.
  - When full, in_ready=0 blocks the push even if a pop occurs that cycle.
- Full: count==DEPTH -> in_ready=0; contents held stable.
- Empty: out_valid=0; out_imm and out_mode hold their last values, and downstream must ignore them.
- Output stability: while out_valid=1 and out_ready=0, out_imm and out_mode must not change.
- Pointer wrap: read and write pointers wrap modulo DEPTH; count is tracked separately, sized for 0..DEPTH.
- Flush:
  - Synchronous; on the edge it clears count and pointers.
  - A push in the same cycle is dropped, and a pop in the same cycle is not counted.
  - out_valid=0 the following cycle; zext_count is not cleared.
- zext_count:
  - Increments by 1 on each pop whose entry mode is zero (and no flush that cycle).
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset mid-operation: all buffered entries are lost; outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset/idle: assert reset with FIFO holding 2 entries -> out_valid=0, zext_count=0 immediately; after release in_ready=1, out_imm=0.
- Decode sweep, out_ready=1:
  - opcode 0x0D, imm 0x8001 -> out_imm 0x00008001, mode 1.
  - 0x08, 0x8001 -> 0xFFFF8001, mode 0.
  - 0x0F, 0x1234 -> 0x12340000, mode 2.
  - 0x04, 0xFFFF -> 0xFFFFFFFC, mode 3.
  - Each result is valid exactly 1 cycle after its push.
- Backpressure: out_ready=0, push 3 entries -> in_ready=0 after the 2nd; the 3rd is held off; head remains the 1st entry, stable. Raise out_ready -> the 3 entries are delivered in order with none lost or duplicated.
- Streaming: 100 back-to-back pushes with out_ready=1 -> 100 outputs in order, in_ready never low, count never exceeds 1.
- Flush: 2 entries buffered, flush asserted together with in_valid=1 -> next cycle out_valid=0, count=0; zext_count unchanged.
- Counter wrap: CNT_W=4, deliver 17 zero-mode entries interleaved with sign-mode entries -> zext_count=1; sign-mode entries do not change it.

Source files
------------

// File: rtl/imm_ext_ctrl.sv
// Immediate-extension stage: decodes the opcode into an extension mode, forms the
// 32-bit operand and buffers it in a small skid FIFO with valid/ready on both sides.
module imm_ext_ctrl #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_opcode,
   input  logic [15:0]      in_imm,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_imm,
   output logic [1:0]       out_mode,
   output logic [CNT_W-1:0] zext_count
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int CW    = (DEPTH > 2) ? 3 : 2;
   localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

   typedef enum logic [1:0] {
      MODE_SIGN   = 2'd0,
      MODE_ZERO   = 2'd1,
      MODE_LUI    = 2'd2,
      MODE_BRANCH = 2'd3
   } mode_e;

   function automatic mode_e decodeMode(input logic [5:0] op);
      case (op)
         6'h0C, 6'h0D, 6'h0E: return MODE_ZERO;
         6'h0F:               return MODE_LUI;
         6'h04, 6'h05:        return MODE_BRANCH;
         default:             return MODE_SIGN;
      endcase
   endfunction

   function automatic logic [31:0] extendImm(input mode_e m, input logic [15:0] imm);
      case (m)
         MODE_ZERO:   return {16'h0000, imm};
         MODE_LUI:    return {imm, 16'h0000};
         MODE_BRANCH: return {{14{imm[15]}}, imm, 2'b00};
         default:     return {{16{imm[15]}}, imm};
      endcase
   endfunction

   logic [31:0]      memImm_r  [DEPTH];
   logic [1:0]       memMode_r [DEPTH];
   logic [PTR_W-1:0] wrPtr_r, rdPtr_r;
   logic [CW-1:0]    count_r;
   logic [31:0]      outImm_r;
   logic [1:0]       outMode_r;
   logic             outValid_r, inReady_r;
   logic [CNT_W-1:0] zextCount_r;

   mode_e            newMode_s;
   logic [31:0]      newImm_s;
   logic             push_s, pop_s;
   logic [PTR_W-1:0] nextWr_s, nextRd_s;
   logic [CW-1:0]    nextCount_s;
   logic [31:0]      headImm_s;
   logic [1:0]       headMode_s;

   // Handshake qualification, pointer/count update and selection of the next head entry.
   always_comb begin
      newMode_s   = decodeMode(in_opcode);
      newImm_s    = extendImm(newMode_s, in_imm);
      push_s      = in_valid & inReady_r & ~flush;
      pop_s       = outValid_r & out_ready & ~flush;
      nextWr_s    = wrPtr_r;
      nextRd_s    = rdPtr_r;
      nextCount_s = count_r;
      headImm_s   = outImm_r;
      headMode_s  = outMode_r;
      if (flush) begin
         nextWr_s    = {PTR_W{1'b0}};
         nextRd_s    = {PTR_W{1'b0}};
         nextCount_s = {CW{1'b0}};
      end else begin
         nextWr_s = push_s ? wrPtr_r + PTR_W'(1) : wrPtr_r;
         nextRd_s = pop_s  ? rdPtr_r + PTR_W'(1) : rdPtr_r;
         case ({push_s, pop_s})
            2'b10:   nextCount_s = count_r + CW'(1);
            2'b01:   nextCount_s = count_r - CW'(1);
            default: nextCount_s = count_r;
         endcase
      end
      // The head register takes the pushed entry directly when nothing older remains.
      if (nextCount_s == {CW{1'b0}}) begin
         headImm_s  = outImm_r;
         headMode_s = outMode_r;
      end else if ((count_r == {CW{1'b0}}) || (pop_s && (count_r == CW'(1)))) begin
         headImm_s  = newImm_s;
         headMode_s = newMode_s;
      end else begin
         headImm_s  = memImm_r[nextRd_s];
         headMode_s = memMode_r[nextRd_s];
      end
   end

   // FIFO storage, pointers, registered outputs and zero-mode delivery counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            memImm_r[i]  <= 32'h0000_0000;
            memMode_r[i] <= 2'd0;
         end
         wrPtr_r     <= {PTR_W{1'b0}};
         rdPtr_r     <= {PTR_W{1'b0}};
         count_r     <= {CW{1'b0}};
         outImm_r    <= 32'h0000_0000;
         outMode_r   <= 2'd0;
         outValid_r  <= 1'b0;
         inReady_r   <= 1'b0;
         zextCount_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            memImm_r[wrPtr_r]  <= newImm_s;
            memMode_r[wrPtr_r] <= newMode_s;
         end else begin
            memImm_r[wrPtr_r]  <= memImm_r[wrPtr_r];
            memMode_r[wrPtr_r] <= memMode_r[wrPtr_r];
         end
         wrPtr_r    <= nextWr_s;
         rdPtr_r    <= nextRd_s;
         count_r    <= nextCount_s;
         outImm_r   <= headImm_s;
         outMode_r  <= headMode_s;
         outValid_r <= (nextCount_s != {CW{1'b0}});
         inReady_r  <= (nextCount_s < DEPTH_V);
         if (pop_s && (outMode_r == MODE_ZERO)) begin
            zextCount_r <= zextCount_r + CNT_W'(1);
         end else begin
            zextCount_r <= zextCount_r;
         end
      end
   end

   assign in_ready   = inReady_r;
   assign out_valid  = outValid_r;
   assign out_imm    = outImm_r;
   assign out_mode   = outMode_r;
   assign zext_count = zextCount_r;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Bench for imm_ext_ctrl: queue-based reference model checked every cycle, plus
// directed literal checks for decode, backpressure, flush, reset and counter wrap.
module tb_imm_ext_ctrl;

   localparam int DEPTH = 2;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    in_opcode;
   logic [15:0]   in_imm;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_imm;
   logic [1:0]    out_mode;
   logic [CW-1:0] zext_count;

   imm_ext_ctrl #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_imm(in_imm), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_mode(out_mode), .zext_count(zext_count)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;
   bit checkEn = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference extension straight from the opcode table, using signed integer arithmetic.
   function automatic logic [33:0] refExt(input logic [5:0] op, input logic [15:0] imm);
      int s;
      s = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
      if (op inside {6'h0C, 6'h0D, 6'h0E}) return {2'd1, 32'(int'(imm))};
      else if (op == 6'h0F)                return {2'd2, 32'(int'(imm) * 65536)};
      else if (op inside {6'h04, 6'h05})   return {2'd3, 32'(s * 4)};
      else                                 return {2'd0, 32'(s)};
   endfunction

   logic [33:0] q[$];
   bit          mReady;
   int          mZext;

   // Reference model: a plain queue of extended entries.
   always @(posedge clk or posedge reset) begin
      bit doPush, doPop;
      if (reset) begin
         q.delete();
         mReady = 1'b0;
         mZext  = 0;
      end else begin
         doPush = in_valid && mReady && !flush;
         doPop  = (q.size() != 0) && out_ready && !flush;
         if (flush) q.delete();
         else begin
            if (doPop) begin
               if (q[0][33:32] == 2'd1) mZext = (mZext + 1) % (1 << CW);
               void'(q.pop_front());
            end
            if (doPush) q.push_back(refExt(in_opcode, in_imm));
         end
         mReady = (q.size() < DEPTH);
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (checkEn && !reset) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(mReady));
         chk("zext_count", 32'(zext_count), 32'(mZext));
         if (q.size() != 0) begin
            chk("out_imm", out_imm, q[0][31:0]);
            chk("out_mode", 32'(out_mode), 32'(q[0][33:32]));
         end
      end
   end

   task automatic step(input bit v, input logic [5:0] op, input logic [15:0] imm,
                       input bit fl, input bit rdy);
      in_valid = v; in_opcode = op; in_imm = imm; flush = fl; out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic expectHead(input string name, input logic [31:0] imm, input logic [1:0] mode);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_imm"}, out_imm, imm);
      chk({name, "_mode"}, 32'(out_mode), 32'(mode));
   endtask

   logic [5:0] opTab [8] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h08, 6'h23};

   function automatic logic [5:0] randOp();
      logic [5:0] r;
      if ($urandom_range(0, 1) == 0) r = opTab[$urandom_range(0, 7)];
      else r = 6'($urandom_range(0, 63));
      return r;
   endfunction

   initial begin
      int zBefore;
      reset = 1'b1; in_valid = 1'b0; in_opcode = 6'h00; in_imm = 16'h0000;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_zext", 32'(zext_count), 32'd0);
      chk("rst_out_imm", out_imm, 32'h0);
      chk("rst_out_mode", 32'(out_mode), 32'd0);
      reset = 1'b0;
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      checkEn = 1'b1;

      // Decode sweep: each result must be the head one cycle after its push.
      step(1'b1, 6'h0D, 16'h8001, 1'b0, 1'b1); expectHead("dec_ori", 32'h0000_8001, 2'd1);
      step(1'b1, 6'h08, 16'h8001, 1'b0, 1'b1); expectHead("dec_addi", 32'hFFFF_8001, 2'd0);
      step(1'b1, 6'h0F, 16'h1234, 1'b0, 1'b1); expectHead("dec_lui", 32'h1234_0000, 2'd2);
      step(1'b1, 6'h04, 16'hFFFF, 1'b0, 1'b1); expectHead("dec_beq", 32'hFFFF_FFFC, 2'd3);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      chk("dec_drained", 32'(out_valid), 32'd0);
      chk("dec_zext", 32'(zext_count), 32'd1);

      // Backpressure: third push held off, then all three drain in order.
      step(1'b1, 6'h0C, 16'h00AA, 1'b0, 1'b0);
      step(1'b1, 6'h08, 16'hF00B, 1'b0, 1'b0);
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      expectHead("bp_head1", 32'h0000_00AA, 2'd1);
      step(1'b1, 6'h0F, 16'h00CC, 1'b0, 1'b0);
      expectHead("bp_head1_hold", 32'h0000_00AA, 2'd1);
      step(1'b1, 6'h0F, 16'h00CC, 1'b0, 1'b1);
      expectHead("bp_head2", 32'hFFFF_F00B, 2'd0);
      step(1'b1, 6'h0F, 16'h00CC, 1'b0, 1'b1);
      expectHead("bp_head3", 32'h00CC_0000, 2'd2);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Streaming: back-to-back pushes must never stall.
      for (int i = 0; i < 100; i++) begin
         step(1'b1, randOp(), 16'($urandom), 1'b0, 1'b1);
         chk("stream_ready", 32'(in_ready), 32'd1);
      end
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);

      // Flush with two zero-mode entries buffered and a push alongside.
      step(1'b1, 6'h0C, 16'h1111, 1'b0, 1'b0);
      step(1'b1, 6'h0E, 16'h2222, 1'b0, 1'b0);
      zBefore = mZext;
      step(1'b1, 6'h0D, 16'h3333, 1'b1, 1'b1);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_zext", 32'(zext_count), 32'(zBefore));
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      chk("flush_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset with two entries buffered.
      step(1'b1, 6'h0C, 16'h4444, 1'b0, 1'b1);
      step(1'b1, 6'h0C, 16'h5555, 1'b0, 1'b0);
      step(1'b1, 6'h08, 16'h6666, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_zext", 32'(zext_count), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("async_rst_ready", 32'(in_ready), 32'd1);
      chk("async_rst_imm", out_imm, 32'h0);

      // Counter wrap: 17 zero-mode deliveries interleaved with sign-mode ones.
      for (int i = 0; i < 34; i++)
         step(1'b1, (i % 2 == 0) ? 6'h0E : 6'h08, 16'($urandom), 1'b0, 1'b1);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      chk("zext_wrap", 32'(zext_count), 32'd1);

      // Random traffic with occasional flushes and backpressure.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0), randOp(), 16'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
